// File: rtl/song_player_pkg.sv
// Shared types and constants for the song playback engine.
// The package is named gv_pkg so other game blocks can share the same state
// and width definitions.
package gv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } player_state_t;

    localparam logic [2:0] PLAY_MODE_DEF = 3'd3;
    localparam int         SONG_LEN      = 32;
    localparam int         POS_W         = 5;

    // Playback walks from the top bit of a lane down to bit 0.
    localparam logic [POS_W-1:0] FIRST_POS = POS_W'(SONG_LEN - 1);
    localparam logic [POS_W-1:0] LAST_POS  = '0;

    // Note bit of a lane pattern at a given playback position.
    function automatic logic note_at(input logic [SONG_LEN-1:0] pattern,
                                     input logic [POS_W-1:0]    pos);
        return pattern[pos];
    endfunction

endpackage

// File: rtl/song_player_beat_timer.sv
// Beat prescaler: counts enabled cycles and raises tick on the last cycle of
// each BEAT_DIV-cycle beat. clr has priority over en, so a restart or abort
// always begins a fresh beat. Holding en low freezes the count (pause).
module beat_timer #(
    parameter int BEAT_DIV = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(BEAT_DIV - 1);

    logic [CW-1:0] count_reg;

    assign tick = en && (count_reg == LAST_COUNT);

    // Beat counter: wraps to zero on the tick cycle, holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            if (count_reg == LAST_COUNT) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/song_player.sv
// Song playback engine: snapshots two 32-bit note lanes on start and steps
// through bit 31 down to 0, one position per BEAT_DIV cycles.
// Optional build macro SONG_PLAYER_LOOP_EN: the song wraps from position 0
// back to 31 and keeps playing instead of finishing in DONE.
module song_player
    import gv_pkg::*;
#(
    parameter int         BEAT_DIV  = 2500000,
    parameter logic [2:0] PLAY_MODE = PLAY_MODE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mode,
    input  logic        start,
    input  logic        pause,
    input  logic [31:0] song1,
    input  logic [31:0] song2,
    output logic        lane1,
    output logic        lane2,
    output logic [4:0]  position,
    output logic        beat_pulse,
    output logic        playing,
    output logic        paused,
    output logic        done
);

    player_state_t        state_reg, state_next;
    logic [POS_W-1:0]     pos_reg, pos_next;
    logic [SONG_LEN-1:0]  snap1_reg, snap2_reg;
    logic                 pulse_reg, pulse_next;
    logic                 snap_load;

    logic                 mode_ok;
    logic                 timer_en;
    logic                 timer_clr;
    logic                 tick;

    assign mode_ok = (mode == PLAY_MODE);

    // The timer only runs on cycles where playback genuinely continues; a
    // pause, restart or mode abort in the same cycle freezes or clears it.
    assign timer_en  = (state_reg == PLAY) && mode_ok && !start && !pause;
    assign timer_clr = !mode_ok || start;

    beat_timer #(
        .BEAT_DIV (BEAT_DIV)
    ) u_beat_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (timer_en),
        .clr  (timer_clr),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: mode gate first, then start (restart wins over pause),
    // then per-state behaviour.
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        pulse_next = 1'b0;
        snap_load  = 1'b0;

        if (!mode_ok) begin
            state_next = IDLE;
            pos_next   = FIRST_POS;
        end else if (start) begin
            state_next = PLAY;
            pos_next   = FIRST_POS;
            snap_load  = 1'b1;
        end else begin
            case (state_reg)
                PLAY: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else if (tick) begin
                        pulse_next = 1'b1;
                        if (pos_reg != LAST_POS) begin
                            pos_next = pos_reg - 1'b1;
                        end else begin
`ifdef SONG_PLAYER_LOOP_EN
                            pos_next = FIRST_POS;
`else
                            state_next = DONE;
`endif
                        end
                    end
                end
                PAUSE: begin
                    if (pause) begin
                        state_next = PLAY;
                    end
                end
                DONE: begin
                    pos_next = LAST_POS;
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    // Datapath registers: position, lane snapshots and the beat strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_reg   <= FIRST_POS;
            snap1_reg <= '0;
            snap2_reg <= '0;
            pulse_reg <= 1'b0;
        end else begin
            pos_reg   <= pos_next;
            pulse_reg <= pulse_next;
            if (snap_load) begin
                snap1_reg <= song1;
                snap2_reg <= song2;
            end
        end
    end

    assign position   = pos_reg;
    assign beat_pulse = pulse_reg;
    assign playing    = (state_reg == PLAY);
    assign paused     = (state_reg == PAUSE);
    assign done       = (state_reg == DONE);

    // Lanes are only live while a song is loaded and in progress.
    assign lane1 = (state_reg == PLAY || state_reg == PAUSE) ? note_at(snap1_reg, pos_reg) : 1'b0;
    assign lane2 = (state_reg == PLAY || state_reg == PAUSE) ? note_at(snap2_reg, pos_reg) : 1'b0;

endmodule

// File: tb/tb_song_player.sv
// Self-checking bench for song_player with BEAT_DIV=4. A behavioural model
// tracks the song as "cycles elapsed in the current beat" and is compared
// against every output on each falling edge.
module tb_song_player;

    localparam int BEAT_DIV = 4;
`ifdef SONG_PLAYER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic        start;
    logic        pause;
    logic [31:0] song1;
    logic [31:0] song2;
    logic        lane1;
    logic        lane2;
    logic [4:0]  position;
    logic        beat_pulse;
    logic        playing;
    logic        paused;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int pulses_seen = 0;

    // Reference model state
    int          m_st;
    int          m_pos;
    int          m_elapsed;
    bit          m_pulse;
    logic [31:0] m_snap1;
    logic [31:0] m_snap2;

    song_player #(
        .BEAT_DIV  (BEAT_DIV),
        .PLAY_MODE (3'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .start      (start),
        .pause      (pause),
        .song1      (song1),
        .song2      (song2),
        .lane1      (lane1),
        .lane2      (lane2),
        .position   (position),
        .beat_pulse (beat_pulse),
        .playing    (playing),
        .paused     (paused),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st      = M_IDLE;
        m_pos     = 31;
        m_elapsed = 0;
        m_pulse   = 1'b0;
        m_snap1   = '0;
        m_snap2   = '0;
    endtask

    // One clock edge of the song rules, using the inputs present at the edge.
    task automatic model_edge();
        m_pulse = 1'b0;
        if (rst) begin
            model_reset();
        end else if (mode != 3'd3) begin
            m_st = M_IDLE;
            m_pos = 31;
            m_elapsed = 0;
        end else if (start) begin
            m_st = M_PLAY;
            m_pos = 31;
            m_elapsed = 0;
            m_snap1 = song1;
            m_snap2 = song2;
        end else if (m_st == M_PLAY) begin
            if (pause) begin
                m_st = M_PAUSE;
            end else begin
                m_elapsed++;
                if (m_elapsed == BEAT_DIV) begin
                    m_elapsed = 0;
                    m_pulse = 1'b1;
                    if (m_pos > 0) m_pos--;
                    else if (LOOP) m_pos = 31;
                    else m_st = M_DONE;
                end
            end
        end else if (m_st == M_PAUSE) begin
            if (pause) m_st = M_PLAY;
        end
    endtask

    task automatic check_model(input string tag);
        bit live;
        live = (m_st == M_PLAY) || (m_st == M_PAUSE);
        chk({tag, ".lane1"},    32'(lane1),      live ? 32'(m_snap1[m_pos]) : 32'd0);
        chk({tag, ".lane2"},    32'(lane2),      live ? 32'(m_snap2[m_pos]) : 32'd0);
        chk({tag, ".position"}, 32'(position),   32'(m_pos));
        chk({tag, ".pulse"},    32'(beat_pulse), 32'(m_pulse));
        chk({tag, ".playing"},  32'(playing),    32'(m_st == M_PLAY));
        chk({tag, ".paused"},   32'(paused),     32'(m_st == M_PAUSE));
        chk({tag, ".done"},     32'(done),       32'(m_st == M_DONE));
    endtask

    // Advance one clock: model follows the edge, outputs checked on negedge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (beat_pulse) pulses_seen++;
        check_model(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst = 1'b1;
        mode = 3'd3;
        start = 1'b0;
        pause = 1'b0;
        song1 = '0;
        song2 = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset.position", 32'(position), 32'd31);
        chk("reset.lanes",    32'({lane1, lane2}), 32'd0);
        chk("reset.flags",    32'({beat_pulse, playing, paused, done}), 32'd0);
        rst = 1'b0;
        step("idle");

        // Basic play
        song1 = 32'h8000_0001;
        song2 = 32'h4000_0000;
        start = 1'b1;
        step("start");
        start = 1'b0;
        chk("basic.pos31",  32'(position), 32'd31);
        chk("basic.lane1",  32'(lane1), 32'd1);
        chk("basic.lane2",  32'(lane2), 32'd0);
        pulses_seen = 0;
        steps(3, "basic");
        step("basic.beat");
        chk("basic.pulse",  32'(beat_pulse), 32'd1);
        chk("basic.pos30",  32'(position), 32'd30);
        chk("basic.lanes30", 32'({lane1, lane2}), 32'b01);

        // End of song: 128 cycles after start
        steps(124, "run");
        chk("end.done",     32'(done), LOOP ? 32'd0 : 32'd1);
        chk("end.playing",  32'(playing), LOOP ? 32'd1 : 32'd0);
        chk("end.position", 32'(position), LOOP ? 32'd31 : 32'd0);
        chk("end.pulses",   32'(pulses_seen), 32'd32);
        steps(8, "after_end");

        // Pause/resume at position 29
        start = 1'b1;
        step("restart");
        start = 1'b0;
        steps(8, "to29");
        chk("pause.pos29", 32'(position), 32'd29);
        steps(2, "into_beat");
        pause = 1'b1;
        step("pause");
        pause = 1'b0;
        chk("pause.paused", 32'(paused), 32'd1);
        pulses_seen = 0;
        steps(10, "held");
        chk("pause.hold_pos",    32'(position), 32'd29);
        chk("pause.hold_pulses", 32'(pulses_seen), 32'd0);
        pause = 1'b1;
        step("resume");
        pause = 1'b0;
        step("resume1");
        chk("resume.not_yet", 32'(position), 32'd29);
        step("resume2");
        chk("resume.pos28", 32'(position), 32'd28);
        chk("resume.pulse", 32'(beat_pulse), 32'd1);

        // Mode abort
        steps(5, "pre_abort");
        mode = 3'd2;
        step("abort");
        chk("abort.playing", 32'(playing), 32'd0);
        chk("abort.lanes",   32'({lane1, lane2}), 32'd0);
        chk("abort.pos",     32'(position), 32'd31);
        start = 1'b1;
        step("abort.start_ignored");
        start = 1'b0;
        mode = 3'd3;
        step("abort.idle");

        // Editor isolation
        song1 = 32'hF0F0_A5A5;
        song2 = 32'h0F0F_5A5A;
        start = 1'b1;
        step("iso.start");
        start = 1'b0;
        song1 = ~song1;
        song2 = ~song2;
        steps(20, "iso");
        chk("iso.lane1", 32'(lane1), 32'(m_snap1[position]));

        // Restart priority at position 10 (21 beats after start)
        start = 1'b1;
        step("rp.start");
        start = 1'b0;
        steps(84, "rp.run");
        chk("rp.pos10", 32'(position), 32'd10);
        song1 = 32'h7FFF_FFFF;
        song2 = 32'h8000_0000;
        start = 1'b1;
        pause = 1'b1;
        step("rp.both");
        start = 1'b0;
        pause = 1'b0;
        chk("rp.playing", 32'(playing), 32'd1);
        chk("rp.pos31",   32'(position), 32'd31);
        chk("rp.newsnap", 32'({lane1, lane2}), 32'b01);

        // Reset mid-beat
        steps(2, "pre_rst");
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rst_mid");
        @(negedge clk);
        check_model("rst_hold");
        rst = 1'b0;
        step("post_rst");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 9) == 0);
            mode  = ($urandom_range(0, 79) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            song1 = $urandom;
            song2 = $urandom;
            step("rand");
        end
        start = 1'b0;
        pause = 1'b0;
        mode = 3'd3;
        step("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
